// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding and mode constants for the channel selector
package fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    localparam logic PRIO_MODE = 1'b0;
    localparam logic RR_MODE   = 1'b1;

endpackage

// File: rtl/fsm_chan_sel_if.sv
// rtl/fsm_chan_sel_if.sv - request/grant bundle between control inputs and channel enables
interface fsm_chan_sel_if #(
    parameter int N_CH  = 3,
    parameter int IDX_W = $clog2(N_CH)
);
    logic [N_CH-1:0]  in;
    logic             rr_mode;
    logic [N_CH-1:0]  out;
    logic [IDX_W-1:0] sel_idx;
    logic             busy;
    logic             timeout;

    modport master (
        output in, rr_mode,
        input  out, sel_idx, busy, timeout
    );

    modport slave (
        input  in, rr_mode,
        output out, sel_idx, busy, timeout
    );
endinterface

// File: rtl/fsm_chan_arb.sv
// rtl/fsm_chan_arb.sv - combinational fixed-priority / round-robin channel picker
module fsm_chan_arb
    import fsm_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic             rr_mode_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the far end so the last hit written is the nearest candidate.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        if (rr_mode_i == RR_MODE) begin
            for (int o = N_CH; o >= 1; o--) begin
                if (req_i[(int'(rr_ptr_i) + o) % N_CH]) begin
                    idx_o = IDX_W'((int'(rr_ptr_i) + o) % N_CH);
                end
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    idx_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fsm_chan_sel.sv
// rtl/fsm_chan_sel.sv - hold-time controlled one-hot channel grant FSM
module fsm_chan_sel
    import fsm_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int MIN_HOLD = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fsm_chan_sel_if.slave bus
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    if (N_CH < 2) begin : g_bad_nch
        $error("fsm_chan_sel: N_CH must be >= 2");
    end
    if (MIN_HOLD < 1) begin : g_bad_min
        $error("fsm_chan_sel: MIN_HOLD must be >= 1");
    end
    if (MAX_HOLD <= MIN_HOLD) begin : g_bad_max
        $error("fsm_chan_sel: MAX_HOLD must exceed MIN_HOLD");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]  out_q, out_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;

    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [CNT_W:0]   done_cnt;
    logic             rel_nat;
    logic             rel_force;

    fsm_chan_arb #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
        .req_i     (bus.in),
        .rr_mode_i (bus.rr_mode),
        .rr_ptr_i  (rr_ptr_q),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    // One bit wider than cnt so the completed-cycle count cannot wrap.
    assign done_cnt  = {1'b0, cnt_q} + 1'b1;
    assign rel_nat   = (done_cnt >= (CNT_W+1)'(MIN_HOLD)) && !bus.in[sel_q];
    assign rel_force = (mode_q == RR_MODE) && (done_cnt == (CNT_W+1)'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mode_q   <= PRIO_MODE;
            rr_ptr_q <= IDX_W'(N_CH - 1);
            out_q    <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            rr_ptr_q <= rr_ptr_d;
            out_q    <= out_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (arb_valid) state_d = S_ACTIVE;
            S_ACTIVE: if (rel_nat || rel_force) state_d = S_GAP;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        rr_ptr_d = rr_ptr_q;
        out_d    = out_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        tmo_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    out_d    = N_CH'(1) << arb_idx;
                    sel_d    = arb_idx;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    mode_d   = bus.rr_mode;
                    rr_ptr_d = arb_idx;
                end
            end
            S_ACTIVE: begin
                if (rel_nat || rel_force) begin
                    out_d  = '0;
                    busy_d = 1'b0;
                    tmo_d  = rel_force;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    // Saturates during an indefinite priority-mode hold.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                out_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.out     = out_q;
    assign bus.sel_idx = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = tmo_q;

    a_out_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_q));
    a_busy_match:  assert property (@(posedge clk) disable iff (!rst_n) busy_q == (|out_q));

endmodule

// File: tb/tb_fsm_chan_sel.sv
// tb/tb_fsm_chan_sel.sv - scoreboard bench for fsm_chan_sel (N_CH=3, MIN_HOLD=2, MAX_HOLD=4)
module tb_fsm_chan_sel;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fsm_chan_sel_if #(.N_CH(3)) bus ();

    fsm_chan_sel #(.N_CH(3), .MIN_HOLD(2), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] out;
        logic [1:0] sel;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string tname    = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_n(input logic [2:0] o, input logic [1:0] s, input logic t, input int n);
        exp_t e;
        e.out  = o;
        e.sel  = s;
        e.busy = |o;
        e.tmo  = t;
        for (int k = 0; k < n; k++) sb_q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] i, input logic rr, input logic rn, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in      = i;
            bus.rr_mode = rr;
            rst_n       = rn;
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check({tname, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({tname, ".out"},     32'(bus.out),     32'(e.out));
                check({tname, ".sel_idx"}, 32'(bus.sel_idx), 32'(e.sel));
                check({tname, ".busy"},    32'(bus.busy),    32'(e.busy));
                check({tname, ".timeout"}, 32'(bus.timeout), 32'(e.tmo));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in      = 3'b000;
        bus.rr_mode = 1'b0;
        rst_n       = 1'b0;

        tname = "reset";
        expect_n(3'b000, 2'd0, 1'b0, 2);
        drive(3'b111, 1'b0, 1'b0, 2);
        expect_n(3'b001, 2'd0, 1'b0, 2);
        expect_n(3'b000, 2'd0, 1'b0, 2);
        drive(3'b111, 1'b0, 1'b1, 1);
        drive(3'b000, 1'b0, 1'b1, 3);

        tname = "short_pulse";
        expect_n(3'b001, 2'd0, 1'b0, 2);
        expect_n(3'b000, 2'd0, 1'b0, 3);
        drive(3'b001, 1'b0, 1'b1, 1);
        drive(3'b000, 1'b0, 1'b1, 4);

        tname = "prio_hold";
        expect_n(3'b010, 2'd1, 1'b0, 10);
        drive(3'b110, 1'b0, 1'b1, 10);
        expect_n(3'b000, 2'd1, 1'b0, 2);
        expect_n(3'b100, 2'd2, 1'b0, 1);
        drive(3'b100, 1'b0, 1'b1, 3);
        expect_n(3'b100, 2'd2, 1'b0, 1);
        expect_n(3'b000, 2'd2, 1'b0, 2);
        drive(3'b000, 1'b0, 1'b1, 3);

        tname = "round_robin";
        for (int r = 0; r < 4; r++) begin
            logic [1:0] ch;
            ch = 2'(r % 3);
            expect_n(3'(1 << ch), ch, 1'b0, 4);
            expect_n(3'b000, ch, 1'b1, 1);
            expect_n(3'b000, ch, 1'b0, 1);
        end
        expect_n(3'b010, 2'd1, 1'b0, 2);
        drive(3'b111, 1'b1, 1'b1, 26);

        tname = "reset_mid";
        expect_n(3'b000, 2'd0, 1'b0, 2);
        drive(3'b111, 1'b1, 1'b0, 2);
        expect_n(3'b001, 2'd0, 1'b0, 1);
        drive(3'b111, 1'b1, 1'b1, 1);
        expect_n(3'b001, 2'd0, 1'b0, 1);
        expect_n(3'b000, 2'd0, 1'b0, 2);
        drive(3'b000, 1'b1, 1'b1, 3);

        tname = "mode_latch";
        expect_n(3'b001, 2'd0, 1'b0, 1);
        drive(3'b001, 1'b0, 1'b1, 1);
        expect_n(3'b001, 2'd0, 1'b0, 5);
        drive(3'b001, 1'b1, 1'b1, 5);
        expect_n(3'b000, 2'd0, 1'b0, 2);
        drive(3'b000, 1'b1, 1'b1, 2);
        expect_n(3'b100, 2'd2, 1'b0, 1);
        drive(3'b101, 1'b1, 1'b1, 1);
        expect_n(3'b100, 2'd2, 1'b0, 1);
        expect_n(3'b000, 2'd2, 1'b0, 2);
        drive(3'b000, 1'b1, 1'b1, 3);

        tname = "timeout_with_drop";
        expect_n(3'b001, 2'd0, 1'b0, 4);
        drive(3'b001, 1'b1, 1'b1, 4);
        expect_n(3'b000, 2'd0, 1'b1, 1);
        expect_n(3'b000, 2'd0, 1'b0, 1);
        drive(3'b000, 1'b1, 1'b1, 2);

        tname = "end";
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
